// File: rtl/mult_issue_ctrl.sv
// Issue-side controller for one shared pipelined multiplier: round-robin pick, shadow of in-flight tags/branch masks, CDB handshake.
// Define MULT_CTRL_PERF_EN to add saturating perf counters (perf_grants, perf_stalls, perf_squashed).
module mult_issue_ctrl #(
   parameter int NUM_REQ = 4,
   parameter int STAGES  = 4,
   parameter int TAG_W   = 6,
   parameter int BMASK_W = 4,
   localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
   input  logic [NUM_REQ*BMASK_W-1:0] req_bmask,
   output logic [NUM_REQ-1:0]         req_grant,
   output logic                       mult_start,
   output logic [SEL_W-1:0]           mult_sel,
   output logic                       mult_stall,
   input  logic [1:0]                 br_task,
   input  logic [BMASK_W-1:0]         br_id,
   output logic                       comp_valid,
   output logic [TAG_W-1:0]           comp_tag,
   output logic [BMASK_W-1:0]         comp_bmask,
   input  logic                       cdb_grant,
`ifdef MULT_CTRL_PERF_EN
   output logic [31:0]                perf_grants,
   output logic [31:0]                perf_stalls,
   output logic [31:0]                perf_squashed,
`endif
   output logic                       busy
);

   localparam logic [1:0] BR_CLEAR  = 2'd1;
   localparam logic [1:0] BR_SQUASH = 2'd2;

   logic               r_sh_valid [STAGES];
   logic [TAG_W-1:0]   r_sh_tag   [STAGES];
   logic [BMASK_W-1:0] r_sh_bmask [STAGES];
   logic [SEL_W-1:0]   r_rr_ptr;

   logic               w_sh_valid [STAGES];
   logic [TAG_W-1:0]   w_sh_tag   [STAGES];
   logic [BMASK_W-1:0] w_sh_bmask [STAGES];
   logic               w_nx_valid [STAGES];
   logic [TAG_W-1:0]   w_nx_tag   [STAGES];
   logic [BMASK_W-1:0] w_nx_bmask [STAGES];

   logic [NUM_REQ-1:0] w_elig;
   logic               w_found;
   logic [SEL_W-1:0]   w_idx;
   logic               w_stall;
   logic               w_start;
   logic [TAG_W-1:0]   w_g_tag;
   logic [BMASK_W-1:0] w_g_bmask;

   // A requester whose own mask hits the branch being squashed must not issue this cycle.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_elig[i] = req_valid[i] &
                     ~((br_task == BR_SQUASH) && (|(req_bmask[i*BMASK_W +: BMASK_W] & br_id)));
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_found = 1'b1;
            w_idx   = SEL_W'((int'(r_rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Shadow is being cleared while reset is high, so no stall can be reported then.
   assign w_stall   = r_sh_valid[STAGES-1] & ~cdb_grant & ~reset;
   assign w_start   = w_found & ~w_stall;
   assign w_g_tag   = req_tag[int'(w_idx)*TAG_W +: TAG_W];
   assign w_g_bmask = req_bmask[int'(w_idx)*BMASK_W +: BMASK_W];

   always_comb begin
      req_grant = '0;
      mult_sel  = '0;
      if (w_start) begin
         req_grant[w_idx] = 1'b1;
         mult_sel         = w_idx;
      end
   end

   assign mult_start = w_start;
   assign mult_stall = w_stall;
   assign comp_valid = r_sh_valid[STAGES-1];
   assign comp_tag   = r_sh_tag[STAGES-1];
   assign comp_bmask = r_sh_bmask[STAGES-1];

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < STAGES; s++) busy = busy | r_sh_valid[s];
   end

   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         w_sh_valid[s] = r_sh_valid[s];
         w_sh_tag[s]   = r_sh_tag[s];
         w_sh_bmask[s] = r_sh_bmask[s];
      end
      if (!w_stall) begin
         for (int s = STAGES-1; s > 0; s--) begin
            w_sh_valid[s] = r_sh_valid[s-1];
            w_sh_tag[s]   = r_sh_tag[s-1];
            w_sh_bmask[s] = r_sh_bmask[s-1];
         end
         w_sh_valid[0] = w_start;
         w_sh_tag[0]   = w_start ? w_g_tag   : '0;
         w_sh_bmask[0] = w_start ? w_g_bmask : '0;
      end
   end

   // Branch resolution acts on next-state, so the entry inserted this cycle is covered too.
   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         w_nx_valid[s] = w_sh_valid[s];
         w_nx_tag[s]   = w_sh_tag[s];
         w_nx_bmask[s] = w_sh_bmask[s];
         if (|(w_sh_bmask[s] & br_id)) begin
            if (br_task == BR_CLEAR) begin
               w_nx_bmask[s] = w_sh_bmask[s] & ~br_id;
            end else if (br_task == BR_SQUASH) begin
               w_nx_valid[s] = 1'b0;
               w_nx_tag[s]   = '0;
               w_nx_bmask[s] = '0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rr_ptr <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_sh_valid[s] <= 1'b0;
            r_sh_tag[s]   <= '0;
            r_sh_bmask[s] <= '0;
         end
      end else begin
         if (w_start) r_rr_ptr <= SEL_W'((int'(w_idx) + 1) % NUM_REQ);
         for (int s = 0; s < STAGES; s++) begin
            r_sh_valid[s] <= w_nx_valid[s];
            r_sh_tag[s]   <= w_nx_tag[s];
            r_sh_bmask[s] <= w_nx_bmask[s];
         end
      end
   end

`ifdef MULT_CTRL_PERF_EN
   logic [31:0] w_squash_cnt;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   always_comb begin
      w_squash_cnt = '0;
      for (int s = 0; s < STAGES; s++) begin
         if ((br_task == BR_SQUASH) && w_sh_valid[s] && (|(w_sh_bmask[s] & br_id)))
            w_squash_cnt = w_squash_cnt + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_grants   <= '0;
         perf_stalls   <= '0;
         perf_squashed <= '0;
      end else begin
         perf_grants   <= sat_add(perf_grants, {31'd0, w_start});
         perf_stalls   <= sat_add(perf_stalls, {31'd0, w_stall});
         perf_squashed <= sat_add(perf_squashed, w_squash_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl: single op, round-robin, backpressure, squash, clear, reset mid-flight.
module tb_mult_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [23:0] req_tag;
   logic [15:0] req_bmask;
   logic [3:0]  req_grant;
   logic        mult_start;
   logic [1:0]  mult_sel;
   logic        mult_stall;
   logic [1:0]  br_task;
   logic [3:0]  br_id;
   logic        comp_valid;
   logic [5:0]  comp_tag;
   logic [3:0]  comp_bmask;
   logic        cdb_grant;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   mult_issue_ctrl #(.NUM_REQ(4), .STAGES(4), .TAG_W(6), .BMASK_W(4)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_tag(req_tag), .req_bmask(req_bmask),
      .req_grant(req_grant), .mult_start(mult_start), .mult_sel(mult_sel),
      .mult_stall(mult_stall), .br_task(br_task), .br_id(br_id),
      .comp_valid(comp_valid), .comp_tag(comp_tag), .comp_bmask(comp_bmask),
      .cdb_grant(cdb_grant), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   // Leaves the bench at a negedge with reset just released; caller drives cycle 0 there.
   task automatic do_reset();
      cyc();
      reset = 1'b1; req_valid = '0; req_tag = '0; req_bmask = '0;
      br_task = 2'd0; br_id = '0; cdb_grant = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_tag = '0; req_bmask = '0;
      br_task = 2'd0; br_id = '0; cdb_grant = 1'b1;

      // single op
      do_reset();
      #1;
      chk_eq("rst_comp_valid", 32'(comp_valid), 0);
      chk_eq("rst_busy", 32'(busy), 0);
      chk_eq("rst_stall", 32'(mult_stall), 0);
      chk_eq("rst_grant", 32'(req_grant), 0);
      chk_eq("rst_start", 32'(mult_start), 0);
      chk_eq("rst_sel", 32'(mult_sel), 0);
      req_valid = 4'b0100; req_tag = {6'd0, 6'd9, 6'd0, 6'd0};
      #1;
      chk_eq("single_grant", 32'(req_grant), 32'h4);
      chk_eq("single_sel", 32'(mult_sel), 2);
      chk_eq("single_start", 32'(mult_start), 1);
      cyc();
      req_valid = '0;
      for (int k = 1; k < 4; k++) begin
         #1 chk_eq("single_early", 32'(comp_valid), 0);
         cyc();
      end
      #1;
      chk_eq("single_comp_valid", 32'(comp_valid), 1);
      chk_eq("single_comp_tag", 32'(comp_tag), 9);
      cyc();
      #1 chk_eq("single_drop", 32'(comp_valid), 0);

      // round-robin
      do_reset();
      req_tag = {6'd23, 6'd22, 6'd21, 6'd20};
      for (int c = 0; c <= 12; c++) begin
         req_valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         if (c < 8) chk_eq("rr_grant", 32'(req_grant), 32'(1 << (c % 4)));
         if (c >= 4 && c < 12) begin
            chk_eq("rr_comp_valid", 32'(comp_valid), 1);
            chk_eq("rr_comp_tag", 32'(comp_tag), 32'(20 + (c - 4) % 4));
         end
         if (c == 12) chk_eq("rr_drain", 32'(comp_valid), 0);
         cyc();
      end

      // backpressure
      do_reset();
      req_tag = {6'd33, 6'd32, 6'd31, 6'd30};
      for (int c = 0; c <= 11; c++) begin
         req_valid = (c < 7) ? 4'hF : 4'h0;
         cdb_grant = (c >= 4 && c < 7) ? 1'b0 : 1'b1;
         #1;
         if (c < 4) chk_eq("bp_grant", 32'(req_grant), 32'(1 << c));
         if (c >= 4 && c < 7) begin
            chk_eq("bp_stall", 32'(mult_stall), 1);
            chk_eq("bp_no_grant", 32'(req_grant), 0);
            chk_eq("bp_no_start", 32'(mult_start), 0);
            chk_eq("bp_tag_stable", 32'(comp_tag), 30);
         end
         if (c >= 7 && c < 11) begin
            chk_eq("bp_stall_off", 32'(mult_stall), 0);
            chk_eq("bp_comp_valid", 32'(comp_valid), 1);
            chk_eq("bp_comp_tag", 32'(comp_tag), 32'(30 + c - 7));
         end
         if (c == 11) begin
            chk_eq("bp_drain", 32'(comp_valid), 0);
            chk_eq("bp_busy", 32'(busy), 0);
         end
         cyc();
      end
      cdb_grant = 1'b1;

      // squash
      do_reset();
      req_tag   = {6'd4, 6'd3, 6'd2, 6'd1};
      req_bmask = {4'b0000, 4'b0001, 4'b0010, 4'b0001};
      for (int c = 0; c <= 8; c++) begin
         req_valid = (c < 3) ? 4'b0111 : (c == 3) ? 4'b0001 : (c == 4) ? 4'b1000 : 4'b0000;
         br_task   = (c == 3) ? 2'd2 : 2'd0;
         br_id     = (c == 3) ? 4'b0001 : 4'b0000;
         #1;
         if (c < 3) chk_eq("sq_issue", 32'(req_grant), 32'(1 << c));
         if (c == 3) begin
            chk_eq("sq_killed_grant", 32'(req_grant), 0);
            chk_eq("sq_killed_start", 32'(mult_start), 0);
         end
         if (c == 4) begin
            chk_eq("sq_rr_hold", 32'(req_grant), 32'h8);
            chk_eq("sq_tag1_gone", 32'(comp_valid), 0);
         end
         if (c == 5) begin
            chk_eq("sq_tag2_valid", 32'(comp_valid), 1);
            chk_eq("sq_tag2", 32'(comp_tag), 2);
         end
         if (c == 6 || c == 7) chk_eq("sq_tag3_gone", 32'(comp_valid), 0);
         if (c == 8) begin
            chk_eq("sq_after_valid", 32'(comp_valid), 1);
            chk_eq("sq_after_tag", 32'(comp_tag), 4);
         end
         cyc();
      end
      br_task = 2'd0; br_id = '0; req_valid = '0;

      // clear mid-pipeline
      do_reset();
      req_tag = {6'd0, 6'd0, 6'd0, 6'd5}; req_bmask = {12'd0, 4'b0011};
      for (int c = 0; c <= 5; c++) begin
         req_valid = (c == 0) ? 4'b0001 : 4'b0000;
         br_task   = (c == 1) ? 2'd1 : 2'd0;
         br_id     = (c == 1) ? 4'b0001 : 4'b0000;
         #1;
         if (c == 2) chk_eq("clr_busy", 32'(busy), 1);
         if (c == 4) begin
            chk_eq("clr_valid", 32'(comp_valid), 1);
            chk_eq("clr_tag", 32'(comp_tag), 5);
            chk_eq("clr_bmask", 32'(comp_bmask), 32'h2);
         end
         if (c == 5) chk_eq("clr_drop", 32'(comp_valid), 0);
         cyc();
      end

      // clear while stalled at the output stage
      do_reset();
      req_tag = {6'd0, 6'd0, 6'd0, 6'd6}; req_bmask = {12'd0, 4'b0011};
      for (int c = 0; c <= 7; c++) begin
         req_valid = (c == 0) ? 4'b0001 : 4'b0000;
         cdb_grant = (c >= 4 && c < 6) ? 1'b0 : 1'b1;
         br_task   = (c == 5) ? 2'd1 : 2'd0;
         br_id     = (c == 5) ? 4'b0001 : 4'b0000;
         #1;
         if (c == 4) begin
            chk_eq("clrs_stall", 32'(mult_stall), 1);
            chk_eq("clrs_bmask_pre", 32'(comp_bmask), 32'h3);
         end
         if (c == 5) chk_eq("clrs_same_cycle", 32'(comp_bmask), 32'h3);
         if (c == 6) begin
            chk_eq("clrs_valid", 32'(comp_valid), 1);
            chk_eq("clrs_tag", 32'(comp_tag), 6);
            chk_eq("clrs_bmask", 32'(comp_bmask), 32'h2);
         end
         if (c == 7) chk_eq("clrs_drop", 32'(comp_valid), 0);
         cyc();
      end
      br_task = 2'd0; br_id = '0; cdb_grant = 1'b1;

      // reset mid-flight
      do_reset();
      req_tag = {6'd43, 6'd42, 6'd41, 6'd40}; req_bmask = '0;
      for (int c = 0; c <= 9; c++) begin
         req_valid = (c < 3) ? 4'b0111 : 4'b0000;
         reset     = (c == 3);
         #1;
         if (c < 3) chk_eq("rmf_issue", 32'(req_grant), 32'(1 << c));
         if (c == 4) chk_eq("rmf_busy", 32'(busy), 0);
         if (c >= 4) chk_eq("rmf_no_comp", 32'(comp_valid), 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
